aq_gemac_tx_frame: RTL and testbench
====================================

Name: aq_gemac_tx_frame

Overview:
- GMII transmit framer for the Giga Ethernet MAC TX path. Sits between the TX payload FIFO and the GMII pins.
- Pulls payload bytes from the FIFO and prepends preamble/SFD. Pads short frames to the minimum length.
- Drives the TX CRC generator (CRC_INIT/CRC_DATA/CRC_ENABLE/CRC_RD), appends the 4 FCS bytes from it, then enforces the inter-frame gap.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD.
- MIN_FRAME, 60, minimum payload+pad bytes excluding FCS; short frames are zero-padded to this length.
- IFG_BYTES, 12, idle cycles after the last FCS byte.

Ports:
- RST_N  in  1  asynchronous reset, active-low
- CLK  in  1  125 MHz TX clock
- TX_DATA  in  8  payload byte from FIFO
- TX_VALID  in  1  TX_DATA valid
- TX_LAST  in  1  TX_DATA is last payload byte of frame
- TX_READY  out  1  byte consumed this cycle (combinational)
- CRC_INIT  out  1  to CRC generator: reset CRC register and byte counter
- CRC_DATA  out  8  to CRC generator: byte being accumulated
- CRC_ENABLE  out  1  to CRC generator: accumulate CRC_DATA
- CRC_RD  out  1  to CRC generator: advance to next FCS byte
- CRC_OUT  in  8  from CRC generator: current FCS byte, wire order
- CRC_END  in  1  from CRC generator: CRC_OUT is the 4th FCS byte
- GMII_TXD  out  8  registered
- GMII_TX_EN  out  1  registered
- GMII_TX_ER  out  1  registered
- TX_DONE  out  1  one-cycle pulse: frame completed normally
- TX_UNDERRUN  out  1  one-cycle pulse: frame aborted
- FRAME_LEN  out  16  bytes sent incl. pad and FCS; valid when TX_DONE is high, held until next TX_DONE

Behaviour:
- Reset values: GMII_TXD=0x00, GMII_TX_EN=0, GMII_TX_ER=0, TX_DONE=0, TX_UNDERRUN=0, FRAME_LEN=0, state=IDLE, all counters 0.
- Reset mid-frame aborts immediately. No FCS or TX_ER is emitted.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IFG.
- GMII outputs are registered from the current state. The GMII byte for state S appears one CLK after the FSM is in S.
- IDLE: GMII_TX_EN=0. TX_VALID=1 → PRE. TX_READY=0.
- First preamble byte: GMII_TX_EN rises after the 2nd CLK edge following TX_VALID being sampled high in IDLE.
- PRE: drive 0x55 for PREAMBLE_LEN cycles → SFD.
- SFD: drive 0xD5 and assert CRC_INIT for that one cycle → DATA. The byte counter is cleared.
- DATA:
  - TX_READY = CRC_ENABLE = TX_VALID; CRC_DATA = TX_DATA; drive TX_DATA; byte counter +1 per consumed byte.
  - If the consumed byte has TX_LAST set: go to PAD if (count+1) < MIN_FRAME, else to FCS.
  - Underrun (TX_VALID=0 in DATA): drive GMII_TX_EN=1, GMII_TX_ER=1, TXD=0x00 for one cycle and pulse TX_UNDERRUN. Go to DROP; no FCS is sent.
- PAD: drive 0x00, CRC_DATA=0x00, CRC_ENABLE=1, count+1. Go to FCS when count+1 == MIN_FRAME. TX_READY=0.
- FCS:
  - CRC_RD=1; drive CRC_OUT; count+1.
  - The generator's byte counter was zeroed by CRC_INIT, so CRC_END is high on the 4th FCS cycle.
  - When CRC_END=1: go to IFG, pulse TX_DONE, load FRAME_LEN = count+1.
  - CRC_ENABLE and CRC_RD are never both high.
- DROP: GMII_TX_EN=0, TX_READY=TX_VALID. Discard bytes until a consumed byte has TX_LAST → IFG.
- IFG: GMII_TX_EN=0 for IFG_BYTES cycles → IDLE. TX_VALID is ignored (TX_READY=0) until IDLE, so back-to-back frames are always gapped by ≥ IFG_BYTES.
- Byte counter is 16 bits and saturates at 0xFFFF; FRAME_LEN saturates likewise. No maximum-length enforcement is done here.
- TX_LAST with TX_VALID=0 is ignored.
- A frame whose only byte carries TX_LAST is legal: 1 data byte, then MIN_FRAME-1 pad bytes.
- CRC_INIT is asserted only in SFD, so the generator state after an abort is irrelevant.

Test Plan:
- 60-byte payload 0x00..0x3B, TX_LAST on last byte → 7×0x55, 0xD5, 60 data bytes, 0 pad, 4 FCS bytes equal to reference CRC-32. TX_EN high exactly 72 cycles; TX_DONE pulse with FRAME_LEN=64.
- 10-byte payload → 10 data bytes + 50 bytes 0x00 + 4 FCS bytes (CRC over data+pad). FRAME_LEN=64; TX_READY high exactly 10 cycles.
- Instance with MIN_FRAME=1, payload ASCII "123456789" (0x31..0x39) → FCS bytes 0x26, 0x39, 0xF4, 0xCB; FRAME_LEN=13.
- Two 64-byte frames with TX_VALID held high → second preamble starts ≥ 12 idle cycles after the last FCS byte of the first; both FCS values correct.
- TX_VALID dropped after 20th data byte of a 100-byte frame → one cycle TX_EN=1/TX_ER=1 and a TX_UNDERRUN pulse. No FCS and no TX_DONE. Remaining 80 bytes are consumed with TX_EN=0; the next frame transmits with correct FCS.
- RST_N asserted during the PAD state → all outputs return to reset values asynchronously. After release, a new 60-byte frame is sent correctly.

Source files
------------

// File: rtl/aq_gemac_tx_frame.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aq_gemac_tx_frame : GMII TX framer - preamble/SFD, pad, FCS, IFG       |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module aq_gemac_tx_frame #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic        RST_N,
    input  logic        CLK,
    input  logic [7:0]  TX_DATA,
    input  logic        TX_VALID,
    input  logic        TX_LAST,
    output logic        TX_READY,
    output logic        CRC_INIT,
    output logic [7:0]  CRC_DATA,
    output logic        CRC_ENABLE,
    output logic        CRC_RD,
    input  logic [7:0]  CRC_OUT,
    input  logic        CRC_END,
    output logic [7:0]  GMII_TXD,
    output logic        GMII_TX_EN,
    output logic        GMII_TX_ER,
    output logic        TX_DONE,
    output logic        TX_UNDERRUN,
    output logic [15:0] FRAME_LEN
);

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        PAD  = 3'd4,
        FCS  = 3'd5,
        DROP = 3'd6,
        IFG  = 3'd7
    } state_t;

    state_t      state, state_nx;
    logic [15:0] gap_cnt, gap_nx;
    logic [15:0] byte_cnt, byte_nx, byte_inc;
    logic [7:0]  txd_nx;
    logic        en_nx, er_nx, done_nx, und_nx;

    // Byte count saturates rather than wrapping on oversize frames.
    assign byte_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            byte_cnt    <= '0;
            GMII_TXD    <= 8'h00;
            GMII_TX_EN  <= 1'b0;
            GMII_TX_ER  <= 1'b0;
            TX_DONE     <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            FRAME_LEN   <= '0;
        end else begin
            state       <= state_nx;
            gap_cnt     <= gap_nx;
            byte_cnt    <= byte_nx;
            GMII_TXD    <= txd_nx;
            GMII_TX_EN  <= en_nx;
            GMII_TX_ER  <= er_nx;
            TX_DONE     <= done_nx;
            TX_UNDERRUN <= und_nx;
            if (done_nx) begin
                FRAME_LEN <= byte_inc;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        gap_nx     = '0;
        byte_nx    = byte_cnt;
        txd_nx     = 8'h00;
        en_nx      = 1'b0;
        er_nx      = 1'b0;
        done_nx    = 1'b0;
        und_nx     = 1'b0;
        TX_READY   = 1'b0;
        CRC_INIT   = 1'b0;
        CRC_DATA   = 8'h00;
        CRC_ENABLE = 1'b0;
        CRC_RD     = 1'b0;
        case (state)
            IDLE: begin
                if (TX_VALID) begin
                    state_nx = PRE;
                end
            end
            PRE: begin
                txd_nx = 8'h55;
                en_nx  = 1'b1;
                if (gap_cnt == PRE_LAST) begin
                    state_nx = SFD;
                end else begin
                    gap_nx = gap_cnt + 16'd1;
                end
            end
            SFD: begin
                txd_nx   = 8'hD5;
                en_nx    = 1'b1;
                CRC_INIT = 1'b1;
                byte_nx  = '0;
                state_nx = DATA;
            end
            DATA: begin
                TX_READY   = TX_VALID;
                CRC_ENABLE = TX_VALID;
                CRC_DATA   = TX_DATA;
                en_nx      = 1'b1;
                if (TX_VALID) begin
                    txd_nx  = TX_DATA;
                    byte_nx = byte_inc;
                    if (TX_LAST) begin
                        state_nx = (byte_inc < MIN_LEN) ? PAD : FCS;
                    end
                end else begin
                    // FIFO ran dry: poison the frame on the wire and abandon it.
                    er_nx    = 1'b1;
                    und_nx   = 1'b1;
                    state_nx = DROP;
                end
            end
            PAD: begin
                en_nx      = 1'b1;
                CRC_ENABLE = 1'b1;
                byte_nx    = byte_inc;
                if (byte_inc == MIN_LEN) begin
                    state_nx = FCS;
                end
            end
            FCS: begin
                CRC_RD  = 1'b1;
                txd_nx  = CRC_OUT;
                en_nx   = 1'b1;
                byte_nx = byte_inc;
                if (CRC_END) begin
                    done_nx  = 1'b1;
                    state_nx = IFG;
                end
            end
            DROP: begin
                TX_READY = TX_VALID;
                if (TX_VALID && TX_LAST) begin
                    state_nx = IFG;
                end
            end
            IFG: begin
                if (gap_cnt == IFG_LAST) begin
                    state_nx = IDLE;
                end else begin
                    gap_nx = gap_cnt + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_aq_gemac_tx_frame.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_aq_gemac_tx_frame : scoreboard bench for the GMII TX framer         |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_aq_gemac_tx_frame;

    localparam int IFG_BYTES = 12;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    typedef logic [7:0] bq_t [$];

    logic        clk;
    logic        rst_n;
    logic [7:0]  tx_data     [2];
    logic        tx_valid    [2];
    logic        tx_last     [2];
    logic        tx_ready    [2];
    logic        crc_init    [2];
    logic [7:0]  crc_data    [2];
    logic        crc_en      [2];
    logic        crc_rd      [2];
    logic [7:0]  crc_out     [2];
    logic        crc_end     [2];
    logic [7:0]  gmii_txd    [2];
    logic        gmii_tx_en  [2];
    logic        gmii_tx_er  [2];
    logic        tx_done     [2];
    logic        tx_underrun [2];
    logic [15:0] frame_len   [2];

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] sq0 [$], sq1 [$], eq0 [$], eq1 [$], lq0 [$], lq1 [$];
    int          ready_cnt [2];
    logic [31:0] last4     [2];

    aq_gemac_tx_frame #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_BYTES(IFG_BYTES)) u_dut0 (
        .RST_N(rst_n), .CLK(clk),
        .TX_DATA(tx_data[0]), .TX_VALID(tx_valid[0]), .TX_LAST(tx_last[0]), .TX_READY(tx_ready[0]),
        .CRC_INIT(crc_init[0]), .CRC_DATA(crc_data[0]), .CRC_ENABLE(crc_en[0]), .CRC_RD(crc_rd[0]),
        .CRC_OUT(crc_out[0]), .CRC_END(crc_end[0]),
        .GMII_TXD(gmii_txd[0]), .GMII_TX_EN(gmii_tx_en[0]), .GMII_TX_ER(gmii_tx_er[0]),
        .TX_DONE(tx_done[0]), .TX_UNDERRUN(tx_underrun[0]), .FRAME_LEN(frame_len[0])
    );

    aq_gemac_tx_frame #(.PREAMBLE_LEN(7), .MIN_FRAME(1), .IFG_BYTES(IFG_BYTES)) u_dut1 (
        .RST_N(rst_n), .CLK(clk),
        .TX_DATA(tx_data[1]), .TX_VALID(tx_valid[1]), .TX_LAST(tx_last[1]), .TX_READY(tx_ready[1]),
        .CRC_INIT(crc_init[1]), .CRC_DATA(crc_data[1]), .CRC_ENABLE(crc_en[1]), .CRC_RD(crc_rd[1]),
        .CRC_OUT(crc_out[1]), .CRC_END(crc_end[1]),
        .GMII_TXD(gmii_txd[1]), .GMII_TX_EN(gmii_tx_en[1]), .GMII_TX_ER(gmii_tx_er[1]),
        .TX_DONE(tx_done[1]), .TX_UNDERRUN(tx_underrun[1]), .FRAME_LEN(frame_len[1])
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx);
        logic [31:0] t;
        t = ~c;
        return t[8*idx +: 8];
    endfunction

    // Behavioural CRC-32 generator attached to each framer instance.
    logic [31:0] crc_st  [2];
    logic [1:0]  crc_idx [2];

    always_ff @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                crc_st[k]  <= '1;
                crc_idx[k] <= '0;
            end else if (crc_init[k]) begin
                crc_st[k]  <= '1;
                crc_idx[k] <= '0;
            end else begin
                if (crc_en[k]) crc_st[k] <= crc_upd(crc_st[k], crc_data[k]);
                if (crc_rd[k]) crc_idx[k] <= crc_idx[k] + 2'd1;
            end
        end
    end

    assign crc_out[0] = fcs_byte(crc_st[0], crc_idx[0]);
    assign crc_out[1] = fcs_byte(crc_st[1], crc_idx[1]);
    assign crc_end[0] = (crc_idx[0] == 2'd3);
    assign crc_end[1] = (crc_idx[1] == 2'd3);

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // which: 0 = GMII byte stream {er,txd}, 1 = done/underrun event, 2 = TX_EN burst length
    task automatic push(input int k, input int which, input logic [31:0] v);
        case ({k[0], which[1:0]})
            3'b000: sq0.push_back(v);
            3'b001: eq0.push_back(v);
            3'b010: lq0.push_back(v);
            3'b100: sq1.push_back(v);
            3'b101: eq1.push_back(v);
            default: lq1.push_back(v);
        endcase
    endtask

    task automatic pop(input int k, input int which, output logic [31:0] v);
        v = EMPTY;
        case ({k[0], which[1:0]})
            3'b000: if (sq0.size() != 0) v = sq0.pop_front();
            3'b001: if (eq0.size() != 0) v = eq0.pop_front();
            3'b010: if (lq0.size() != 0) v = lq0.pop_front();
            3'b100: if (sq1.size() != 0) v = sq1.pop_front();
            3'b101: if (eq1.size() != 0) v = eq1.pop_front();
            default: if (lq1.size() != 0) v = lq1.pop_front();
        endcase
    endtask

    function automatic int qsz(input int k);
        if (k == 0) return sq0.size() + eq0.size() + lq0.size();
        return sq1.size() + eq1.size() + lq1.size();
    endfunction

    task automatic flush(input int k);
        if (k == 0) begin sq0.delete(); eq0.delete(); lq0.delete(); end
        else        begin sq1.delete(); eq1.delete(); lq1.delete(); end
    endtask

    // Expected wire image of a frame; stop_at >= 0 models an underrun after that many bytes.
    task automatic push_frame(input int k, input bq_t p, input int stop_at);
        logic [31:0] crc;
        int n;
        int minf;
        minf = (k == 0) ? 60 : 1;
        for (int i = 0; i < 7; i++) push(k, 0, 32'h055);
        push(k, 0, 32'h0D5);
        if (stop_at >= 0) begin
            for (int i = 0; i < stop_at; i++) push(k, 0, {24'h0, p[i]});
            push(k, 0, 32'h100);
            push(k, 1, 32'h1_0000);
            push(k, 2, 32'(8 + stop_at + 1));
        end else begin
            crc = '1;
            n   = 0;
            foreach (p[i]) begin
                push(k, 0, {24'h0, p[i]});
                crc = crc_upd(crc, p[i]);
                n++;
            end
            while (n < minf) begin
                push(k, 0, 32'h000);
                crc = crc_upd(crc, 8'h00);
                n++;
            end
            for (int b = 0; b < 4; b++) push(k, 0, {24'h0, fcs_byte(crc, 2'(b))});
            push(k, 1, 32'(n + 4));
            push(k, 2, 32'(8 + n + 4));
        end
    endtask

    task automatic send(input int k, input bq_t p, input int stop_at, input bit hold);
        int   cyc;
        logic rdy;
        for (int i = 0; i < p.size(); i++) begin
            if (i == stop_at) begin
                tx_valid[k] = 1'b0;
                tx_last[k]  = 1'b0;
                @(posedge clk); #1;
            end
            tx_data[k]  = p[i];
            tx_valid[k] = 1'b1;
            tx_last[k]  = (i == p.size() - 1);
            cyc = 0;
            rdy = 1'b0;
            while (!rdy) begin
                @(negedge clk);
                rdy = tx_ready[k];
                @(posedge clk); #1;
                cyc++;
                if (!rdy && cyc > 400) begin
                    check_value("ready_timeout", 32'(cyc), 32'd0);
                    tx_valid[k] = 1'b0;
                    return;
                end
            end
        end
        if (!hold) begin
            tx_valid[k] = 1'b0;
            tx_last[k]  = 1'b0;
        end
    endtask

    task automatic drain(input int k);
        int cyc;
        cyc = 0;
        while (qsz(k) != 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_value("drain", 32'(qsz(k)), 32'd0);
        repeat (IFG_BYTES + 2) @(negedge clk);
    endtask

    // Output monitor: compares the GMII stream, pulses and burst lengths with the scoreboard.
    initial begin
        logic        prev_en [2];
        int          en_run  [2];
        int          idle_run[2];
        bit          had_frame[2];
        logic [31:0] v;
        for (int k = 0; k < 2; k++) begin
            prev_en[k] = 1'b0; en_run[k] = 0; idle_run[k] = 0; had_frame[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    prev_en[k] = 1'b0; en_run[k] = 0; idle_run[k] = 0; had_frame[k] = 1'b0;
                end else begin
                    if (tx_ready[k]) ready_cnt[k]++;
                    if (gmii_tx_en[k]) begin
                        if (!prev_en[k] && had_frame[k])
                            check_value("ifg_gap_ok", 32'(idle_run[k] >= IFG_BYTES), 32'd1);
                        en_run[k]++;
                        idle_run[k] = 0;
                        pop(k, 0, v);
                        check_value(k == 0 ? "gmii0" : "gmii1", {23'h0, gmii_tx_er[k], gmii_txd[k]}, v);
                        last4[k] = {last4[k][23:0], gmii_txd[k]};
                    end else begin
                        if (prev_en[k]) begin
                            had_frame[k] = 1'b1;
                            pop(k, 2, v);
                            check_value("tx_en_len", 32'(en_run[k]), v);
                            en_run[k] = 0;
                        end
                        idle_run[k]++;
                        check_value("tx_er_idle", {31'h0, gmii_tx_er[k]}, 32'd0);
                    end
                    if (tx_done[k]) begin
                        pop(k, 1, v);
                        check_value("frame_len", {16'h0, frame_len[k]}, v);
                    end
                    if (tx_underrun[k]) begin
                        pop(k, 1, v);
                        check_value("underrun", {15'h0, tx_underrun[k], 16'h0}, v);
                    end
                    prev_en[k] = gmii_tx_en[k];
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t p;
        bq_t p2;
        for (int k = 0; k < 2; k++) begin
            tx_data[k] = 8'h00; tx_valid[k] = 1'b0; tx_last[k] = 1'b0;
            ready_cnt[k] = 0; last4[k] = '0;
        end
        rst_n = 1'b0;
        #10;
        check_value("rst_txd",      {24'h0, gmii_txd[0]},    32'h0);
        check_value("rst_tx_en",    {31'h0, gmii_tx_en[0]},  32'h0);
        check_value("rst_tx_er",    {31'h0, gmii_tx_er[0]},  32'h0);
        check_value("rst_done",     {31'h0, tx_done[0]},     32'h0);
        check_value("rst_underrun", {31'h0, tx_underrun[0]}, 32'h0);
        check_value("rst_len",      {16'h0, frame_len[0]},   32'h0);
        check_value("rst_ready",    {31'h0, tx_ready[0]},    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Exactly-minimum frame: no pad
        p = {};
        for (int i = 0; i < 60; i++) p.push_back(8'(i));
        push_frame(0, p, -1);
        ready_cnt[0] = 0;
        send(0, p, -1, 1'b0);
        drain(0);
        check_value("ready_cnt_60", 32'(ready_cnt[0]), 32'd60);

        // Short frame padded to 60
        p = {};
        for (int i = 0; i < 10; i++) p.push_back(8'hA0 + 8'(i));
        push_frame(0, p, -1);
        ready_cnt[0] = 0;
        send(0, p, -1, 1'b0);
        drain(0);
        check_value("ready_cnt_10", 32'(ready_cnt[0]), 32'd10);

        // Single-byte frame
        p = {8'h7E};
        push_frame(0, p, -1);
        ready_cnt[0] = 0;
        send(0, p, -1, 1'b0);
        drain(0);
        check_value("ready_cnt_1", 32'(ready_cnt[0]), 32'd1);

        // MIN_FRAME=1 instance, classic CRC check string
        p = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_frame(1, p, -1);
        ready_cnt[1] = 0;
        send(1, p, -1, 1'b0);
        drain(1);
        check_value("fcs_123456789", last4[1], 32'h2639_F4CB);
        check_value("ready_cnt_9", 32'(ready_cnt[1]), 32'd9);

        // Back-to-back 64-byte frames with TX_VALID held high
        p = {};
        p2 = {};
        for (int i = 0; i < 64; i++) begin
            p.push_back(8'($urandom));
            p2.push_back(8'($urandom));
        end
        push_frame(0, p, -1);
        send(0, p, -1, 1'b1);
        push_frame(0, p2, -1);
        send(0, p2, -1, 1'b0);
        drain(0);

        // Underrun after 20 bytes of a 100-byte frame, then a clean frame
        p = {};
        for (int i = 0; i < 100; i++) p.push_back(8'($urandom));
        push_frame(0, p, 20);
        ready_cnt[0] = 0;
        send(0, p, 20, 1'b0);
        drain(0);
        check_value("ready_cnt_drop", 32'(ready_cnt[0]), 32'd100);
        p = {};
        for (int i = 0; i < 30; i++) p.push_back(8'($urandom));
        push_frame(0, p, -1);
        send(0, p, -1, 1'b0);
        drain(0);

        // Asynchronous reset while padding
        p = {};
        for (int i = 0; i < 10; i++) p.push_back(8'h11 * 8'(i));
        push_frame(0, p, -1);
        send(0, p, -1, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        flush(0);
        check_value("arst_txd",   {24'h0, gmii_txd[0]},   32'h0);
        check_value("arst_tx_en", {31'h0, gmii_tx_en[0]}, 32'h0);
        check_value("arst_tx_er", {31'h0, gmii_tx_er[0]}, 32'h0);
        check_value("arst_len",   {16'h0, frame_len[0]},  32'h0);
        check_value("arst_crc_en", {31'h0, crc_en[0]},    32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        p = {};
        for (int i = 0; i < 60; i++) p.push_back(8'hFF - 8'(i));
        push_frame(0, p, -1);
        ready_cnt[0] = 0;
        send(0, p, -1, 1'b0);
        drain(0);
        check_value("ready_cnt_post_rst", 32'(ready_cnt[0]), 32'd60);

        check_value("final_q0", 32'(qsz(0)), 32'd0);
        check_value("final_q1", 32'(qsz(1)), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
